// File: rtl/uart_tx_arb_if.sv
// Bundle of requester-side and UART-FIFO-side signals around uart_tx_arb.
//   req, req_data, req_last : per-requester byte valid / byte / last-of-packet
//   ack, gnt, busy          : per-requester accept strobe, current owner, packet active
//   timeout_tick            : one-cycle pulse when a stalled owner loses its grant
//   wr_uart, w_data, tx_full: write side of the UART transmit FIFO
// Modports:
//   slave  - the arbiter
//   master - the producers plus the UART FIFO
interface uart_tx_arb_if #(
   parameter int NREQ = 4,
   parameter int DBIT = 8
);
   logic [NREQ-1:0]      req;
   logic [NREQ*DBIT-1:0] req_data;
   logic [NREQ-1:0]      req_last;
   logic [NREQ-1:0]      ack;
   logic [NREQ-1:0]      gnt;
   logic                 busy;
   logic                 timeout_tick;
   logic                 wr_uart;
   logic [DBIT-1:0]      w_data;
   logic                 tx_full;

   modport slave (
      input  req, req_data, req_last, tx_full,
      output ack, gnt, busy, timeout_tick, wr_uart, w_data
   );

   modport master (
      output req, req_data, req_last, tx_full,
      input  ack, gnt, busy, timeout_tick, wr_uart, w_data
   );
endinterface

// File: rtl/uart_tx_arb.sv
// Packet-atomic round-robin arbiter in front of one UART TX FIFO.
// A requester keeps the grant from its first byte until its last byte is
// accepted; a requester that stops supplying bytes mid-packet loses the grant
// after TIMEOUT stall cycles. FIFO backpressure never counts as a stall.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset
//   bus    - uart_tx_arb_if.slave (requesters and UART FIFO write side)
//
// Optional build macro UART_TX_ARB_HDR_EN: after arbitration one header byte
// {4'hA, owner index} is written ahead of the packet (no ack for it).
//
// state | meaning
// IDLE  | no owner; round-robin pick among asserted req bits
// HDR   | owner chosen; writing the header byte (UART_TX_ARB_HDR_EN only)
// XFER  | forwarding owner bytes until its last byte or a stall timeout
module uart_tx_arb #(
   parameter int NREQ    = 4,
   parameter int DBIT    = 8,
   parameter int TIMEOUT = 1024,
   parameter int TO_BIT  = 10
) (
   input logic          clk,
   input logic          reset,
   uart_tx_arb_if.slave bus
);
   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef UART_TX_ARB_HDR_EN
   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, HDR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1} state_t;
`endif

   state_t            state, state_nx;
   logic [OW-1:0]     owner, owner_nx;
   logic [OW-1:0]     last_owner, last_owner_nx;
   logic [TO_BIT-1:0] stall_cnt, stall_cnt_nx;

   logic              pick_vld;
   logic [OW-1:0]     pick_idx;
   logic [OW-1:0]     cand;
   logic              own_req;
   logic              accept;
   logic [NREQ-1:0]   ack_c;
   logic              wr_c;
   logic [DBIT-1:0]   wdat_c;
   logic              tick_c;

   // Search starts just after the previous owner so it gets lowest priority.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = OW'((int'(last_owner) + k) % NREQ);
         if (!pick_vld && bus.req[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   assign own_req = bus.req[owner];
   assign accept  = (state == XFER) && own_req && !bus.tx_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OW'(NREQ - 1);
         stall_cnt  <= '0;
      end else begin
         state      <= state_nx;
         owner      <= owner_nx;
         last_owner <= last_owner_nx;
         stall_cnt  <= stall_cnt_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      owner_nx      = owner;
      last_owner_nx = last_owner;
      stall_cnt_nx  = stall_cnt;
      ack_c         = '0;
      wr_c          = 1'b0;
      wdat_c        = '0;
      tick_c        = 1'b0;
      case (state)
         IDLE: begin
            stall_cnt_nx = '0;
            if (pick_vld) begin
               owner_nx = pick_idx;
`ifdef UART_TX_ARB_HDR_EN
               state_nx = HDR;
`else
               state_nx = XFER;
`endif
            end
         end
`ifdef UART_TX_ARB_HDR_EN
         HDR: begin
            wdat_c = DBIT'({4'hA, 4'(owner)});
            wr_c   = !bus.tx_full;
            if (!bus.tx_full) state_nx = XFER;
         end
`endif
         XFER: begin
            wdat_c       = bus.req_data[int'(owner)*DBIT +: DBIT];
            wr_c         = accept;
            ack_c[owner] = accept;
            if (accept) begin
               stall_cnt_nx = '0;
               if (bus.req_last[owner]) begin
                  state_nx      = IDLE;
                  last_owner_nx = owner;
               end
            end else if (!own_req) begin
               // req held with tx_full high falls through: counter holds.
               if (stall_cnt == TO_BIT'(TIMEOUT - 1)) begin
                  tick_c        = 1'b1;
                  state_nx      = IDLE;
                  last_owner_nx = owner;
                  stall_cnt_nx  = '0;
               end else begin
                  stall_cnt_nx = stall_cnt + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.ack          = ack_c;
   assign bus.wr_uart      = wr_c;
   assign bus.w_data       = wdat_c;
   assign bus.timeout_tick = tick_c;
   assign bus.busy         = (state != IDLE);
   assign bus.gnt          = (state != IDLE) ? (NREQ'(1) << owner) : '0;
endmodule
